// File: rtl/axi4_lite_pkg.sv
// Shared constants for the AXI4-Lite register slave: response codes,
// handshake FSM state encodings and a constant-foldable clog2.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_ACCEPT = 1'b0,
        W_RESP   = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_ACCEPT = 1'b0,
        R_DATA   = 1'b1
    } rd_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage for the AXI4-Lite slave: write merge, per-register write pulse,
// registered read port. Byte-strobe merge enabled by AXI4_LITE_REG_SLAVE_WSTRB_EN.
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int DATA_W_IN_BYTES = 4,
    parameter int NUM_REGS        = 16,
    parameter int IDX_W           = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [IDX_W-1:0]                     wr_idx,
    input  logic [DATA_W_IN_BYTES*8-1:0]         wr_data,
    input  logic [DATA_W_IN_BYTES-1:0]           wr_strb,
    input  logic                                 rd_en,
    input  logic [IDX_W-1:0]                     rd_idx,
    output logic [DATA_W_IN_BYTES*8-1:0]         rd_data,
    output logic [NUM_REGS*DATA_W_IN_BYTES*8-1:0] reg_out,
    output logic [NUM_REGS-1:0]                  wr_pulse
);

    localparam int DATA_W = DATA_W_IN_BYTES * 8;

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Read samples storage before any same-edge write lands, so a colliding read sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                rd_data <= '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (32'(rd_idx) == i) begin
                        rd_data <= mem[i];
                    end
                end
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= wr_en && (32'(wr_idx) == i);
                if (wr_en && (32'(wr_idx) == i)) begin
`ifdef AXI4_LITE_REG_SLAVE_WSTRB_EN
                    for (int b = 0; b < DATA_W_IN_BYTES; b++) begin
                        if (wr_strb[b]) begin
                            mem[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
`else
                    mem[i] <= wr_data;
`endif
                end
            end
        end
    end

`ifndef AXI4_LITE_REG_SLAVE_WSTRB_EN
    logic unused_strb;
    assign unused_strb = ^wr_strb;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite word-addressed register slave with independent single-outstanding read/write.
// Byte-strobe writes are enabled by defining AXI4_LITE_REG_SLAVE_WSTRB_EN.
//
// state    | meaning
// W_ACCEPT | collecting AW and W in any order; commits once both are held
// W_RESP   | BVALID/BRESP held until BREADY
// R_ACCEPT | ARREADY high, waiting for a read address
// R_DATA   | RVALID/RDATA/RRESP held until RREADY
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int DATA_W_IN_BYTES = 4,
    parameter int ADDR_W_IN_BITS  = 10,
    parameter int NUM_REGS        = 16
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic [ADDR_W_IN_BITS-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                            S_AXI_AWPROT,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [DATA_W_IN_BYTES*8-1:0]          S_AXI_WDATA,
    input  logic [DATA_W_IN_BYTES-1:0]            S_AXI_WSTRB,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [1:0]                            S_AXI_BRESP,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [ADDR_W_IN_BITS-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                            S_AXI_ARPROT,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    output logic [DATA_W_IN_BYTES*8-1:0]          S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY,
    output logic [NUM_REGS*DATA_W_IN_BYTES*8-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]                   WR_PULSE
);

    localparam int DATA_W    = DATA_W_IN_BYTES * 8;
    localparam int BYTE_BITS = clog2(DATA_W_IN_BYTES);
    localparam int IDX_W     = ADDR_W_IN_BITS - BYTE_BITS;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic                       aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]           wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic [DATA_W_IN_BYTES-1:0] wstrb_q, wstrb_d;
    logic                       awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic                       wr_commit, wr_in_range, rd_en, rd_in_range;
    logic [IDX_W-1:0]           rd_idx;

    assign rd_idx      = S_AXI_ARADDR[ADDR_W_IN_BITS-1:BYTE_BITS];
    assign wr_in_range = 32'(wr_idx_q) < NUM_REGS;
    assign rd_in_range = 32'(rd_idx) < NUM_REGS;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        wr_idx_d   = wr_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            W_ACCEPT: begin
                if (aw_held_q && w_held_q) begin
                    wr_commit  = 1'b1;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = W_RESP;
                end else begin
                    if (S_AXI_AWVALID && awready_q) begin
                        aw_held_d = 1'b1;
                        wr_idx_d  = S_AXI_AWADDR[ADDR_W_IN_BITS-1:BYTE_BITS];
                    end
                    if (S_AXI_WVALID && wready_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_ACCEPT;
                end
            end
            default: wr_state_d = W_ACCEPT;
        endcase
        awready_d = (wr_state_d == W_ACCEPT) && !aw_held_d;
        wready_d  = (wr_state_d == W_ACCEPT) && !w_held_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rd_en      = 1'b0;
        case (rd_state_q)
            R_ACCEPT: begin
                if (S_AXI_ARVALID && arready_q) begin
                    rd_en      = 1'b1;
                    rvalid_d   = 1'b1;
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_ACCEPT;
                end
            end
            default: rd_state_d = R_ACCEPT;
        endcase
        arready_d = (rd_state_d == R_ACCEPT);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_ACCEPT;
            rd_state_q <= R_ACCEPT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            wr_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            wr_idx_q   <= wr_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
        end
    end

    axi4_lite_reg_bank #(
        .DATA_W_IN_BYTES(DATA_W_IN_BYTES),
        .NUM_REGS       (NUM_REGS),
        .IDX_W          (IDX_W)
    ) u_bank (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (wr_commit && wr_in_range),
        .wr_idx  (wr_idx_q),
        .wr_data (wdata_q),
        .wr_strb (wstrb_q),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (S_AXI_RDATA),
        .reg_out (REG_OUT),
        .wr_pulse(WR_PULSE)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench for axi4_lite_reg_slave against an array-based register model.
// Exercises strobe merging only when AXI4_LITE_REG_SLAVE_WSTRB_EN is defined.
module tb_axi4_lite_reg_slave;

    localparam int NB = 4;
    localparam int AW = 10;
    localparam int NR = 16;
    localparam int DW = NB * 8;
`ifdef AXI4_LITE_REG_SLAVE_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [AW-1:0] AWADDR = '0, ARADDR = '0;
    logic [2:0]    AWPROT = '0, ARPROT = '0;
    logic          AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic [DW-1:0] WDATA = '0;
    logic [NB-1:0] WSTRB = '0;
    logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]    BRESP, RRESP;
    logic [DW-1:0] RDATA;
    logic [NR*DW-1:0] REG_OUT;
    logic [NR-1:0] WR_PULSE;

    axi4_lite_reg_slave #(.DATA_W_IN_BYTES(NB), .ADDR_W_IN_BITS(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] model_regs [NR];
    int pulse_cnt [NR] = '{default: 0};
    int bvalid_rises = 0;
    logic bvalid_prev = 1'b0;

    always @(negedge ACLK) begin
        for (int i = 0; i < NR; i++) if (WR_PULSE[i] === 1'b1) pulse_cnt[i]++;
        if (BVALID === 1'b1 && !bvalid_prev) bvalid_rises++;
        bvalid_prev = (BVALID === 1'b1);
    end

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pulse_cnt[i];
        return s;
    endfunction

    // Reference model: a plain array indexed by address / bytes-per-word.
    task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [NB-1:0] strb, output logic [1:0] resp);
        int idx = int'(addr) / NB;
        if (idx < NR) begin
            for (int b = 0; b < NB; b++)
                if (!STRB_EN || strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            resp = 2'b00;
        end else resp = 2'b10;
    endtask

    task automatic model_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                              output logic [1:0] resp);
        int idx = int'(addr) / NB;
        if (idx < NR) begin data = model_regs[idx]; resp = 2'b00; end
        else begin data = '0; resp = 2'b10; end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
    endtask

    // Drivers are entered and left 1 time unit after a rising edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [NB-1:0] strb, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int n = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1; WVALID = 1; BREADY = 1;
        while (!(aw_done && w_done) && n < 50) begin
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            @(posedge ACLK); #1; n++;
            if (hs_aw) begin AWVALID = 0; aw_done = 1; end
            if (hs_w)  begin WVALID = 0;  w_done = 1;  end
        end
        while (BVALID !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
        resp = 2'bxx;
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL write_timeout addr=%h got no BVALID within 50 cycles, required BVALID", addr);
            AWVALID = 0; WVALID = 0;
        end else begin
            resp = BRESP;
            @(posedge ACLK); #1;
        end
        BREADY = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp);
        bit hs, done = 0;
        int n = 0;
        ARADDR = addr; ARVALID = 1; RREADY = 1;
        while (!done && n < 50) begin
            hs = ARVALID && ARREADY;
            @(posedge ACLK); #1; n++;
            if (hs) begin ARVALID = 0; done = 1; end
        end
        while (RVALID !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
        data = 'x; resp = 2'bxx;
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL read_timeout addr=%h got no RVALID within 50 cycles, required RVALID", addr);
            ARVALID = 0;
        end else begin
            data = RDATA; resp = RRESP;
            @(posedge ACLK); #1;
        end
        RREADY = 0;
    endtask

    task automatic test_reset();
        ARESET = 1;
        repeat (3) @(posedge ACLK);
        #1;
        vectors++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b required 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP});
        end
        vectors++;
        if ({RDATA, WR_PULSE} !== '0 || REG_OUT !== '0) begin
            miscompares++;
            $display("FAIL reset_data got rdata=%h pulse=%h required 0", RDATA, WR_PULSE);
        end
        ARESET = 0;
        model_clear();
        @(posedge ACLK); #1;
        vectors++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b required 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d; logic [1:0] r;
        int snap [NR]; int tot;
        do_read(10'h020, d, r);
        vectors++;
        if (d !== 32'd0 || r !== 2'b00) begin
            miscompares++; $display("FAIL read_before_write got %h/%b required 0/00", d, r);
        end
        snap = pulse_cnt; tot = total_pulses();
        model_write(10'h020, 32'd33, '1, r);
        do_write(10'h020, 32'd33, '1, r);
        vectors++;
        if (r !== 2'b00) begin miscompares++; $display("FAIL write_h20_bresp got %b required 00", r); end
        repeat (2) @(posedge ACLK);
        #1;
        vectors++;
        if (pulse_cnt[8] - snap[8] != 1 || total_pulses() - tot != 1) begin
            miscompares++;
            $display("FAIL wr_pulse_8 got %0d cycles (total %0d) required 1", pulse_cnt[8] - snap[8], total_pulses() - tot);
        end
        do_read(10'h020, d, r);
        vectors++;
        if (d !== 32'd33 || r !== 2'b00) begin
            miscompares++; $display("FAIL read_h20 got %h/%b required 21/00", d, r);
        end
        do_read(10'h023, d, r);
        vectors++;
        if (d !== model_regs[8] || r !== 2'b00) begin
            miscompares++; $display("FAIL read_unaligned got %h/%b required %h/00", d, r, model_regs[8]);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d; logic [1:0] r, er;
        int snap [NR]; int tot;
        tot = total_pulses();
        model_write(10'h040, 32'hff, '1, er);
        do_write(10'h040, 32'hff, '1, r);
        repeat (2) @(posedge ACLK);
        #1;
        vectors++;
        if (r !== er || total_pulses() != tot) begin
            miscompares++;
            $display("FAIL oor_write got resp=%b pulses=%0d required %b/0", r, total_pulses() - tot, er);
        end
        do_read(10'h040, d, r);
        vectors++;
        if (d !== 32'd0 || r !== 2'b10) begin
            miscompares++; $display("FAIL oor_read got %h/%b required 0/10", d, r);
        end
        snap = pulse_cnt;
        model_write(10'h03c, 32'hcafe_0015, '1, er);
        do_write(10'h03c, 32'hcafe_0015, '1, r);
        do_read(10'h03c, d, r);
        vectors++;
        if (d !== 32'hcafe_0015 || r !== 2'b00 || pulse_cnt[15] - snap[15] != 1) begin
            miscompares++; $display("FAIL last_reg got %h/%b required cafe0015/00", d, r);
        end
    endtask

    task automatic test_handshake_order();
        logic [AW-1:0] a; logic [DW-1:0] d, rd; logic [1:0] er, r;
        int snap_b, tot, idx, pi0;
        for (int order = 0; order < 2; order++) begin
            a = (order == 0) ? 10'h010 : 10'h014;
            idx = (order == 0) ? 4 : 5;
            d = $urandom;
            snap_b = bvalid_rises; tot = total_pulses(); pi0 = pulse_cnt[idx];
            model_write(a, d, '1, er);
            BREADY = 0; AWADDR = a; WDATA = d; WSTRB = '1;
            if (order == 0) AWVALID = 1; else WVALID = 1;
            @(posedge ACLK); #1;
            if (order == 0) AWVALID = 0; else WVALID = 0;
            vectors++;
            if ({AWREADY, WREADY} !== ((order == 0) ? 2'b01 : 2'b10)) begin
                miscompares++; $display("FAIL first_ready_drop order=%0d got %b", order, {AWREADY, WREADY});
            end
            repeat (2) @(posedge ACLK);
            #1;
            vectors++;
            if ({AWREADY, WREADY, BVALID} !== ((order == 0) ? 3'b010 : 3'b100)) begin
                miscompares++; $display("FAIL half_held order=%0d got %b", order, {AWREADY, WREADY, BVALID});
            end
            if (order == 0) WVALID = 1; else AWVALID = 1;
            @(posedge ACLK); #1;
            AWVALID = 0; WVALID = 0;
            vectors++;
            if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
                miscompares++; $display("FAIL both_held order=%0d got %b required 000", order, {AWREADY, WREADY, BVALID});
            end
            @(posedge ACLK); #1;
            vectors++;
            if (BVALID !== 1'b1 || BRESP !== er) begin
                miscompares++; $display("FAIL bvalid_latency got %b/%b required 1/%b", BVALID, BRESP, er);
            end
            for (int c = 0; c < 5; c++) begin
                @(posedge ACLK); #1;
                vectors++;
                if ({BVALID, BRESP, AWREADY, WREADY} !== {1'b1, er, 2'b00}) begin
                    miscompares++; $display("FAIL bresp_stable cycle=%0d got %b", c, {BVALID, BRESP, AWREADY, WREADY});
                end
            end
            BREADY = 1;
            @(posedge ACLK); #1;
            BREADY = 0;
            vectors++;
            if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
                miscompares++; $display("FAIL bresp_done got %b required 011", {BVALID, AWREADY, WREADY});
            end
            vectors++;
            if (bvalid_rises - snap_b != 1 || total_pulses() - tot != 1 || pulse_cnt[idx] - pi0 != 1) begin
                miscompares++;
                $display("FAIL single_commit got bvalid=%0d pulses=%0d required 1/1", bvalid_rises - snap_b, total_pulses() - tot);
            end
            do_read(a, rd, r);
            vectors++;
            if (rd !== d || r !== 2'b00) begin
                miscompares++; $display("FAIL order_readback got %h/%b required %h/00", rd, r, d);
            end
        end
    endtask

    task automatic test_multi();
        logic [AW-1:0] addrs [4] = '{10'h000, 10'h000, 10'h004, 10'h008};
        logic [DW-1:0] datas [4] = '{32'h0, 32'hff, 32'h1, 32'h2};
        logic [DW-1:0] d, ed; logic [1:0] r, er;
        for (int i = 0; i < 4; i++) begin
            model_write(addrs[i], datas[i], '1, er);
            do_write(addrs[i], datas[i], '1, r);
            vectors++;
            if (r !== er) begin miscompares++; $display("FAIL multi_bresp %0d got %b required %b", i, r, er); end
        end
        for (int i = 0; i < 3; i++) begin
            model_read(10'(i * 4), ed, er);
            do_read(10'(i * 4), d, r);
            vectors++;
            if (d !== ed || r !== er) begin
                miscompares++; $display("FAIL multi_read %0d got %h/%b required %h/%b", i, d, r, ed, er);
            end
        end
        for (int i = 0; i < NR; i++) begin
            vectors++;
            if (REG_OUT[i*DW +: DW] !== model_regs[i]) begin
                miscompares++; $display("FAIL reg_out_%0d got %h required %h", i, REG_OUT[i*DW +: DW], model_regs[i]);
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] old, d; logic [1:0] er, r;
        old = model_regs[2];
        model_write(10'h008, 32'd7, '1, er);
        AWADDR = 10'h008; WDATA = 32'd7; WSTRB = '1; AWVALID = 1; WVALID = 1; BREADY = 0;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARADDR = 10'h008; ARVALID = 1; RREADY = 0;
        @(posedge ACLK); #1;
        ARVALID = 0;
        vectors++;
        if ({RVALID, BVALID} !== 2'b11 || RDATA !== old || RRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL collision_old got rv=%b bv=%b rdata=%h required 1/1/%h", RVALID, BVALID, RDATA, old);
        end
        BREADY = 1; RREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0; RREADY = 0;
        vectors++;
        if ({RVALID, BVALID, ARREADY, AWREADY} !== 4'b0011) begin
            miscompares++; $display("FAIL collision_done got %b required 0011", {RVALID, BVALID, ARREADY, AWREADY});
        end
        do_read(10'h008, d, r);
        vectors++;
        if (d !== 32'd7 || r !== 2'b00) begin
            miscompares++; $display("FAIL collision_new got %h/%b required 7/00", d, r);
        end
    endtask

    task automatic pulse_reset(input string tag);
        ARESET = 1;
        @(posedge ACLK); #1;
        ARESET = 0;
        model_clear();
        vectors++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, WR_PULSE} !== '0
            || RDATA !== '0 || REG_OUT !== '0) begin
            miscompares++;
            $display("FAIL %s_zero got ctrl=%b rdata=%h pulse=%h", tag,
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, RDATA, WR_PULSE);
        end
        @(posedge ACLK); #1;
        vectors++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
            miscompares++; $display("FAIL %s_ready got %b required 11100", tag, {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] d, ed; logic [1:0] r, er;
        AWADDR = 10'h00c; WDATA = 32'h1234_5678; WSTRB = '1; AWVALID = 1; WVALID = 1; BREADY = 0;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        @(posedge ACLK); #1;
        vectors++;
        if (BVALID !== 1'b1) begin miscompares++; $display("FAIL inflight_bvalid got %b required 1", BVALID); end
        pulse_reset("rst_bvalid");
        model_write(10'h018, 32'h5a5a_a5a5, '1, er);
        do_write(10'h018, 32'h5a5a_a5a5, '1, r);
        ARADDR = 10'h018; ARVALID = 1; RREADY = 0;
        @(posedge ACLK); #1;
        ARVALID = 0;
        vectors++;
        if (RVALID !== 1'b1 || RDATA !== 32'h5a5a_a5a5) begin
            miscompares++; $display("FAIL inflight_rvalid got %b/%h required 1/5a5aa5a5", RVALID, RDATA);
        end
        pulse_reset("rst_rvalid");
        d = $urandom;
        model_write(10'h01c, d, '1, er);
        do_write(10'h01c, d, '1, r);
        model_read(10'h01c, ed, er);
        do_read(10'h01c, d, r);
        vectors++;
        if (d !== ed || r !== er) begin
            miscompares++; $display("FAIL post_reset_txn got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

`ifdef AXI4_LITE_REG_SLAVE_WSTRB_EN
    task automatic test_wstrb();
        logic [DW-1:0] d; logic [1:0] r, er;
        int p0;
        model_write(10'h000, 32'hffff_ffff, 4'b1111, er);
        do_write(10'h000, 32'hffff_ffff, 4'b1111, r);
        model_write(10'h000, 32'h1122_3344, 4'b0101, er);
        do_write(10'h000, 32'h1122_3344, 4'b0101, r);
        do_read(10'h000, d, r);
        vectors++;
        if (d !== 32'hff22_ff44 || r !== 2'b00) begin
            miscompares++; $display("FAIL wstrb_merge got %h/%b required ff22ff44/00", d, r);
        end
        p0 = pulse_cnt[0];
        model_write(10'h000, 32'h0, 4'b0000, er);
        do_write(10'h000, 32'h0, 4'b0000, r);
        vectors++;
        if (r !== 2'b00 || pulse_cnt[0] - p0 != 1) begin
            miscompares++; $display("FAIL wstrb_zero got resp=%b pulses=%0d required 00/1", r, pulse_cnt[0] - p0);
        end
        do_read(10'h000, d, r);
        vectors++;
        if (d !== 32'hff22_ff44) begin
            miscompares++; $display("FAIL wstrb_zero_data got %h required ff22ff44", d);
        end
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] a; logic [DW-1:0] d, ed; logic [NB-1:0] s; logic [1:0] r, er;
        for (int i = 0; i < 60; i++) begin
            a = 10'($urandom_range(0, 'h4f));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                model_write(a, d, s, er);
                do_write(a, d, s, r);
                vectors++;
                if (r !== er) begin
                    miscompares++; $display("FAIL rand_write %0d addr=%h got %b required %b", i, a, r, er);
                end
            end else begin
                model_read(a, ed, er);
                do_read(a, d, r);
                vectors++;
                if (d !== ed || r !== er) begin
                    miscompares++; $display("FAIL rand_read %0d addr=%h got %h/%b required %h/%b", i, a, d, r, ed, er);
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            vectors++;
            if (REG_OUT[i*DW +: DW] !== model_regs[i]) begin
                miscompares++; $display("FAIL rand_reg_out_%0d got %h required %h", i, REG_OUT[i*DW +: DW], model_regs[i]);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_out_of_range();
        test_handshake_order();
        test_multi();
        test_collision();
        test_reset_inflight();
`ifdef AXI4_LITE_REG_SLAVE_WSTRB_EN
        test_wstrb();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion by 200000 time units, required $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
AXI4-Lite responder: a word-addressed read/write register bank driven by the team's AXI4-Lite initiator bench. It sits at the far end of the S_AXI_* bus and exposes register contents and per-register write pulses to fabric logic. It handles one outstanding write and one outstanding read, with independent read and write channels.

Parameters:
DATA_W_IN_BYTES, 4, data bus width in bytes; data width is DATA_W_IN_BYTES*8.
ADDR_W_IN_BITS, 10, AXI address width.
NUM_REGS, 16, number of RW registers at word indices 0..NUM_REGS-1; must be at most 2^(ADDR_W_IN_BITS-clog2(DATA_W_IN_BYTES)).

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  reset, synchronous, active-high.
S_AXI_AWADDR  in  ADDR_W_IN_BITS  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  DATA_W_IN_BYTES*8  write data.
S_AXI_WSTRB  in  DATA_W_IN_BYTES  byte strobes (see Optional Feature).
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  ADDR_W_IN_BITS  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  DATA_W_IN_BYTES*8  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
REG_OUT  out  NUM_REGS*DATA_W_IN_BYTES*8  flattened register contents; register i at slice i.
WR_PULSE  out  NUM_REGS  one-cycle pulse on the bit of the register written.

Behaviour:
- Reset (ARESET=1 at a rising edge): all registers, REG_OUT, WR_PULSE, BVALID, RVALID, RDATA and BRESP/RRESP go to 0. AWREADY, WREADY and ARREADY go to 0. Any in-flight transaction is dropped. AW/W/ARREADY go to 1 on the first edge with ARESET=0.
- Decode: word index = ADDR[ADDR_W_IN_BITS-1:clog2(DATA_W_IN_BYTES)]. Low byte bits are ignored. Index >= NUM_REGS is out of range.
- Write FSM states:
  - W_ACCEPT: AWREADY=!aw_held, WREADY=!w_held. AW and W are captured independently, in any order or in the same cycle. Each ready drops on the edge after its handshake.
  - When both are held, the FSM goes to W_RESP on the following edge. On that same edge: commit the write if in range, pulse WR_PULSE for 1 cycle, assert BVALID, and set BRESP=OKAY(00) or SLVERR(10).
  - Out-of-range write: storage is unchanged and WR_PULSE stays 0.
  - W_RESP: hold BVALID/BRESP until BVALID&BREADY at an edge. Then BVALID=0, clear the held flags, AW/WREADY=1, and return to W_ACCEPT.
  - Latency: both handshakes at edge N -> register updated and BVALID=1 after edge N+1.
- Read FSM states:
  - R_ACCEPT: ARREADY=1. At ARVALID&ARREADY on edge N: ARREADY=0, sample RDATA from storage as it stands before any write committed at edge N, set RRESP, RVALID=1; go to R_DATA.
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
  - R_DATA: hold RVALID/RDATA/RRESP stable until RVALID&RREADY. Then RVALID=0, ARREADY=1, return to R_ACCEPT.
- Concurrency: the read and write channels are fully independent.
- Same-register collision: a read accepted on the same edge a write commits returns the old value.
- Outputs are stable while VALID is high and READY is low; no combinational path from input to output.

Optional Feature:
AXI4_LITE_REG_SLAVE_WSTRB_EN
- Defined: only bytes with WSTRB[b]=1 are written. WSTRB=0 commits nothing but still pulses WR_PULSE and returns OKAY.
- Undefined: WSTRB is ignored and every write is a full-word write. This is the default, because the bench initiator drives WSTRB=0.

Decomposition:
- Package axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write and read FSM state encodings, and a clog2 function.
- Sub-module axi4_lite_reg_bank: storage array, strobe merge, WR_PULSE generation, registered read port.
- The handshake FSMs stay in the top level.

Test Plan:
- Write 'h20 <- 33, then read 'h20 -> RDATA=33, RRESP=00, WR_PULSE[8] high for exactly 1 cycle.
- Read 'h20 before any write -> RDATA=0, OKAY. Write 'h40 (index 16) <- 'hff -> BRESP=10, no WR_PULSE. Read 'h40 -> RDATA=0, RRESP=10.
- AWVALID 3 cycles before WVALID, then the reverse order -> AWREADY/WREADY each drop after their own handshake, exactly one commit, BVALID exactly once, BREADY held low 5 cycles -> BVALID/BRESP stable throughout.
- Write 'h00 <- 'h0, 'h00 <- 'hff, 'h04 <- 1, 'h08 <- 2; read all -> 'hff, 1, 2; REG_OUT slices match.
- Read 'h08 accepted on the same edge a write of 'h08 <- 7 commits -> RDATA=2; next read -> 7.
- ARESET pulsed for 1 cycle while BVALID is pending and again while RVALID is pending -> all outputs 0, registers 0, readies 1 one cycle after release; the next transaction completes normally.
- With the _EN macro: write 'h0 <- 'h11223344 with WSTRB='b0101 over 'hffffffff -> read 'hff22ff44.
